factor_witness_search: RTL and testbench

- Sequential solution generator for the multiplier-factorization SAT benchmarks. Where the benchmark circuit checks a given (a,b) assignment against a product, this block produces that assignment.
- Walks candidate pairs (a,b) in a fixed order and multiplies each pair with a shift-add datapath. It compares every product against a latched target.
- Reports the first satisfying pair (the witness), or reports UNSAT when no pair matches.
- Used on-FPGA as a golden reference to cross-check solver results for the multiplier_N_sat instances.

---
 rtl/factor_witness_search.sv | 143 ++++++++++++++
 tb/tb_factor_witness_search.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/factor_witness_search.sv
// Exhaustive factor search: walks (a,b) candidates, multiplies each with a shift-add
// datapath and reports the first pair whose product equals the latched target.
module factor_witness_search #(
  parameter int unsigned A_W             = 3,
  parameter int unsigned B_W             = 2,
  parameter bit          EXCLUDE_TRIVIAL = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [A_W+B_W-1:0]   i_target,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_found,
  output logic [A_W-1:0]       o_a_out,
  output logic [B_W-1:0]       o_b_out,
  output logic [A_W+B_W:0]     o_tried
);

  localparam int unsigned PW     = A_W + B_W;
  localparam int unsigned TriedW = PW + 1;
  localparam int unsigned IdxW   = (B_W > 1) ? $clog2(B_W) : 1;
  localparam int unsigned Lo     = EXCLUDE_TRIVIAL ? 2 : 0;

  localparam logic [A_W-1:0]    ALo     = A_W'(Lo);
  localparam logic [B_W-1:0]    BLo     = B_W'(Lo);
  localparam logic [IdxW-1:0]   IdxLast = IdxW'(B_W - 1);
  localparam logic [IdxW-1:0]   IdxOne  = IdxW'(1);
  localparam logic [A_W-1:0]    AOne    = A_W'(1);
  localparam logic [B_W-1:0]    BOne    = B_W'(1);
  localparam logic [TriedW-1:0] TriedOne = TriedW'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StMul, StCmp, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [PW-1:0]      r_target;
  logic [PW-1:0]      r_acc;
  logic [A_W-1:0]     r_a;
  logic [B_W-1:0]     r_b;
  logic [IdxW-1:0]    r_idx;
  logic [TriedW-1:0]  r_tried;
  logic               r_found;
  logic [A_W-1:0]     r_a_out;
  logic [B_W-1:0]     r_b_out;

  logic [PW-1:0]      w_addend;
  logic               w_hit;
  logic               w_last;

  // Partial product for the current multiplier bit, widened so nothing is truncated.
  assign w_addend = {{B_W{1'b0}}, r_a} << r_idx;
  assign w_hit    = (r_acc == r_target);
  assign w_last   = (&r_a) && (&r_b);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StLoad;
      StLoad:  w_state_next = StMul;
      StMul:   if (r_idx == IdxLast) w_state_next = StCmp;
      StCmp:   w_state_next = (w_hit || w_last) ? StDone : StMul;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_busy  = (r_state == StLoad) || (r_state == StMul) || (r_state == StCmp);
    o_done  = (r_state == StDone);
    o_found = r_found;
    o_a_out = r_a_out;
    o_b_out = r_b_out;
    o_tried = r_tried;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_tried  <= '0;
      r_found  <= 1'b0;
      r_a_out  <= '0;
      r_b_out  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_target <= i_target;
            r_tried  <= '0;
            r_found  <= 1'b0;
          end
        end
        StLoad: begin
          r_a   <= ALo;
          r_b   <= BLo;
          r_acc <= '0;
          r_idx <= '0;
        end
        StMul: begin
          if (r_b[r_idx]) r_acc <= r_acc + w_addend;
          r_idx <= r_idx + IdxOne;
        end
        StCmp: begin
          r_tried <= r_tried + TriedOne;
          if (w_hit) begin
            r_a_out <= r_a;
            r_b_out <= r_b;
            r_found <= 1'b1;
          end else if (w_last) begin
            r_found <= 1'b0;
          end else begin
            // a is the inner loop; wrapping it steps b.
            if (&r_a) begin
              r_a <= ALo;
              r_b <= r_b + BOne;
            end else begin
              r_a <= r_a + AOne;
            end
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        StDone: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_factor_witness_search.sv
// Directed bench for factor_witness_search: default instance plus an EXCLUDE_TRIVIAL=0 instance.
module tb_factor_witness_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic [4:0] target0, target1;

  logic       d0_busy, d0_done, d0_found;
  logic [2:0] d0_a;
  logic [1:0] d0_b;
  logic [5:0] d0_tried;
  logic       d1_busy, d1_done, d1_found;
  logic [2:0] d1_a;
  logic [1:0] d1_b;
  logic [5:0] d1_tried;

  logic       sel = 1'b0;
  logic       m_busy, m_done, m_found;
  logic [2:0] m_a;
  logic [1:0] m_b;
  logic [5:0] m_tried;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done0  = 0;

  factor_witness_search #(.A_W(3), .B_W(2), .EXCLUDE_TRIVIAL(1'b1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_target(target0),
    .o_busy(d0_busy), .o_done(d0_done), .o_found(d0_found),
    .o_a_out(d0_a), .o_b_out(d0_b), .o_tried(d0_tried)
  );

  factor_witness_search #(.A_W(3), .B_W(2), .EXCLUDE_TRIVIAL(1'b0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_target(target1),
    .o_busy(d1_busy), .o_done(d1_done), .o_found(d1_found),
    .o_a_out(d1_a), .o_b_out(d1_b), .o_tried(d1_tried)
  );

  always #5 clk = ~clk;

  assign m_busy  = sel ? d1_busy  : d0_busy;
  assign m_done  = sel ? d1_done  : d0_done;
  assign m_found = sel ? d1_found : d0_found;
  assign m_a     = sel ? d1_a     : d0_a;
  assign m_b     = sel ? d1_b     : d0_b;
  assign m_tried = sel ? d1_tried : d0_tried;

  always @(negedge clk) if (d0_done) n_done0++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Launches one search and counts rising edges after the accepting edge until done is seen.
  task automatic search(input logic s, input logic [4:0] tgt, input logic hold,
                        input logic [4:0] tgt_after, output int edges);
    sel = s;
    repeat (2) @(negedge clk);
    if (s) begin start1 = 1'b1; target1 = tgt; end
    else   begin start0 = 1'b1; target0 = tgt; end
    @(posedge clk);
    #1;
    if (s) begin target1 = tgt_after; if (!hold) start1 = 1'b0; end
    else   begin target0 = tgt_after; if (!hold) start0 = 1'b0; end
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (m_done) break;
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic check_result(input string tag, input int edges, input int exp_edges,
                              input logic found, input logic [2:0] a, input logic [1:0] b,
                              input logic [5:0] tried);
    check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    check({tag, "_found"}, 32'(m_found), 32'(found));
    check({tag, "_a"}, 32'(m_a), 32'(a));
    check({tag, "_b"}, 32'(m_b), 32'(b));
    check({tag, "_tried"}, 32'(m_tried), 32'(tried));
    check({tag, "_busy"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    int e;
    int snap;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; target0 = '0; target1 = '0;
    #1;
    check("rst_busy", 32'(d0_busy), 32'd0);
    check("rst_done", 32'(d0_done), 32'd0);
    check("rst_found", 32'(d0_found), 32'd0);
    check("rst_a", 32'(d0_a), 32'd0);
    check("rst_b", 32'(d0_b), 32'd0);
    check("rst_tried", 32'(d0_tried), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    search(1'b0, 5'd15, 1'b0, 5'd15, e);
    check_result("t15", e, 31, 1'b1, 3'd5, 2'd3, 6'd10);
    @(posedge clk); #1;
    check("t15_done_pulse", 32'(d0_done), 32'd0);

    search(1'b0, 5'd13, 1'b0, 5'd13, e);
    check_result("t13", e, 37, 1'b0, 3'd5, 2'd3, 6'd12);

    search(1'b0, 5'd4, 1'b0, 5'd4, e);
    check_result("t4", e, 4, 1'b1, 3'd2, 2'd2, 6'd1);

    search(1'b1, 5'd0, 1'b0, 5'd0, e);
    check_result("nt_t0", e, 4, 1'b1, 3'd0, 2'd0, 6'd1);
    search(1'b1, 5'd21, 1'b0, 5'd21, e);
    check_result("nt_t21", e, 97, 1'b1, 3'd7, 2'd3, 6'd32);

    // start held through the run; target disturbed after acceptance.
    snap = n_done0;
    search(1'b0, 5'd15, 1'b1, 5'd4, e);
    check_result("hold", e, 31, 1'b1, 3'd5, 2'd3, 6'd10);
    repeat (3) @(posedge clk);
    #1;
    check("hold_idle_busy", 32'(d0_busy), 32'd0);
    check("hold_one_done", 32'(n_done0 - snap), 32'd1);
    search(1'b0, 5'd4, 1'b0, 5'd4, e);
    check_result("restart", e, 4, 1'b1, 3'd2, 2'd2, 6'd1);

    // Asynchronous reset mid-search.
    sel = 1'b0;
    repeat (2) @(negedge clk);
    start0 = 1'b1; target0 = 5'd15;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", 32'(d0_busy), 32'd1);
    snap = n_done0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(d0_busy), 32'd0);
    check("arst_done", 32'(d0_done), 32'd0);
    check("arst_found", 32'(d0_found), 32'd0);
    check("arst_a", 32'(d0_a), 32'd0);
    check("arst_b", 32'(d0_b), 32'd0);
    check("arst_tried", 32'(d0_tried), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_no_done", 32'(n_done0 - snap), 32'd0);
    search(1'b0, 5'd15, 1'b0, 5'd15, e);
    check_result("post_rst", e, 31, 1'b1, 3'd5, 2'd3, 6'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
